// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access stage: bus layouts,
// memory-op codes and FSM state encoding.
package mem_stage_pkg;

  localparam int DATA_W   = 32;
  localparam int ALU_OP_W = 12;
  localparam int REG_IDX_W = 5;

  // Memory operation codes carried in ex_ctrl_bus.mem_op; unlisted codes act as MEM_NONE
  localparam logic [3:0] MEM_NONE = 4'd0;
  localparam logic [3:0] MEM_LB   = 4'd1;
  localparam logic [3:0] MEM_LBU  = 4'd2;
  localparam logic [3:0] MEM_LH   = 4'd3;
  localparam logic [3:0] MEM_LHU  = 4'd4;
  localparam logic [3:0] MEM_LW   = 4'd5;
  localparam logic [3:0] MEM_SB   = 4'd6;
  localparam logic [3:0] MEM_SH   = 4'd7;
  localparam logic [3:0] MEM_SW   = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  // Execute -> memory bus, MSB first
  typedef struct packed {
    logic [3:0]           mem_op;
    logic [ALU_OP_W-1:0]  alu_op;
    logic                 inst_valid;
    logic [DATA_W-1:0]    imm;
    logic [DATA_W-1:0]    pc;
    logic [DATA_W-1:0]    inst;
    logic [REG_IDX_W-1:0] wreg_index;
    logic                 wreg_en;
    logic [DATA_W-1:0]    src2;
    logic [DATA_W-1:0]    src1;
    logic [DATA_W-1:0]    alu_result;
  } ex_ctrl_t;

  // Memory -> write-back bus, MSB first
  typedef struct packed {
    logic                 ale;
    logic                 inst_valid;
    logic [DATA_W-1:0]    pc;
    logic [DATA_W-1:0]    inst;
    logic [REG_IDX_W-1:0] wreg_index;
    logic                 wreg_en;
    logic [DATA_W-1:0]    result;
  } mem_ctrl_t;

  localparam int EX_CTRL_W  = $bits(ex_ctrl_t);
  localparam int MEM_CTRL_W = $bits(mem_ctrl_t);

endpackage

// File: rtl/mem_align.sv
// Combinational memory formatting: store byte enables and data replication,
// load byte/half extraction with sign or zero extension, misalignment detect.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [3:0]        mem_op,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] src2,
  input  logic [DATA_W-1:0] rdata,
  output logic              is_mem,
  output logic              is_store,
  output logic              misaligned,
  output logic [3:0]        wstrb,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data
);

  function automatic logic [DATA_W-1:0] sext8(input logic [7:0] b);
    logic signed [7:0]        s;
    logic signed [DATA_W-1:0] r;
    s = signed'(b);
    r = s;
    return unsigned'(r);
  endfunction

  function automatic logic [DATA_W-1:0] sext16(input logic [15:0] h);
    logic signed [15:0]       s;
    logic signed [DATA_W-1:0] r;
    s = signed'(h);
    r = s;
    return unsigned'(r);
  endfunction

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Pick the addressed byte and halfword lanes out of the read word
  always_comb begin
    rbyte = rdata[7:0];
    case (addr_lo)
      2'd0: rbyte = rdata[7:0];
      2'd1: rbyte = rdata[15:8];
      2'd2: rbyte = rdata[23:16];
      2'd3: rbyte = rdata[31:24];
      default: rbyte = rdata[7:0];
    endcase
    rhalf = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Decode the op into request shape, alignment check and load formatting
  always_comb begin
    is_mem     = 1'b0;
    is_store   = 1'b0;
    misaligned = 1'b0;
    wstrb      = 4'b0000;
    wdata      = src2;
    load_data  = rdata;
    case (mem_op)
      MEM_LB: begin
        is_mem    = 1'b1;
        load_data = sext8(rbyte);
      end
      MEM_LBU: begin
        is_mem    = 1'b1;
        load_data = {24'd0, rbyte};
      end
      MEM_LH: begin
        is_mem     = 1'b1;
        misaligned = addr_lo[0];
        load_data  = sext16(rhalf);
      end
      MEM_LHU: begin
        is_mem     = 1'b1;
        misaligned = addr_lo[0];
        load_data  = {16'd0, rhalf};
      end
      MEM_LW: begin
        is_mem     = 1'b1;
        misaligned = |addr_lo;
        load_data  = rdata;
      end
      MEM_SB: begin
        is_mem   = 1'b1;
        is_store = 1'b1;
        wstrb    = 4'b0001 << addr_lo;
        wdata    = {4{src2[7:0]}};
      end
      MEM_SH: begin
        is_mem     = 1'b1;
        is_store   = 1'b1;
        misaligned = addr_lo[0];
        wstrb      = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{src2[15:0]}};
      end
      MEM_SW: begin
        is_mem     = 1'b1;
        is_store   = 1'b1;
        misaligned = |addr_lo;
        wstrb      = 4'b1111;
        wdata      = src2;
      end
      default: begin
        is_mem = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage. Accepts execute results over a valid/ready
// handshake, runs load/store transactions on a split address/data memory
// port, and hands formatted results to write-back over a second handshake.
// DONE is the "result presented" state: it may accept the next op in the
// same cycle its result drains, which gives one op per cycle for ALU ops.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [EX_CTRL_W-1:0]  ex_ctrl_bus,
  input  logic                  left_valid,
  output logic                  left_ready,
  output logic                  right_valid,
  input  logic                  right_ready,
  output logic [MEM_CTRL_W-1:0] mem_ctrl_bus,
  output logic                  data_req,
  output logic                  data_we,
  output logic [3:0]            data_wstrb,
  output logic [DATA_W-1:0]     data_addr,
  output logic [DATA_W-1:0]     data_wdata,
  input  logic                  data_addr_ok,
  input  logic                  data_data_ok,
  input  logic [DATA_W-1:0]     data_rdata
);

  ex_ctrl_t ex_in;
  assign ex_in = ex_ctrl_t'(ex_ctrl_bus);

  // Fields the memory stage never consumes
  logic unused_fields;
  assign unused_fields = ^{ex_in.alu_op, ex_in.imm, ex_in.src1};

  state_e    state_p0;
  logic      req_p0;
  logic      vld_p1;
  mem_ctrl_t out_p1;

  // Captured memory-op context, valid from accept until the op completes
  logic [3:0]           op_p0;
  logic [DATA_W-1:0]    addr_p0;
  logic                 we_p0;
  logic [3:0]           wstrb_p0;
  logic [DATA_W-1:0]    wdata_p0;
  logic                 iv_p0;
  logic [DATA_W-1:0]    pc_p0;
  logic [DATA_W-1:0]    inst_p0;
  logic [REG_IDX_W-1:0] widx_p0;
  logic                 wen_p0;

  logic fire_in;
  logic busy;
  assign busy       = (state_p0 == REQ) || (state_p0 == WAIT);
  assign left_ready = ((state_p0 == IDLE) || (state_p0 == DONE)) && (!vld_p1 || right_ready);
  assign fire_in    = left_valid && left_ready;

  // While a transaction is outstanding the formatter looks at the captured
  // op; otherwise it decodes the op being offered for acceptance.
  logic [3:0]        al_op;
  logic [1:0]        al_addr_lo;
  logic              al_is_mem;
  logic              al_is_store;
  logic              al_misaligned;
  logic [3:0]        al_wstrb;
  logic [DATA_W-1:0] al_wdata;
  logic [DATA_W-1:0] al_load;

  assign al_op      = busy ? op_p0 : ex_in.mem_op;
  assign al_addr_lo = busy ? addr_p0[1:0] : ex_in.alu_result[1:0];

  mem_align u_align (
    .mem_op     (al_op),
    .addr_lo    (al_addr_lo),
    .src2       (ex_in.src2),
    .rdata      (data_rdata),
    .is_mem     (al_is_mem),
    .is_store   (al_is_store),
    .misaligned (al_misaligned),
    .wstrb      (al_wstrb),
    .wdata      (al_wdata),
    .load_data  (al_load)
  );

  // ALU ops, misaligned accesses: address / ALU result passes straight through
  mem_ctrl_t pass_out;
  // Completed memory ops: loads report formatted data, stores report the address
  mem_ctrl_t mem_out;

  always_comb begin
    pass_out            = '0;
    pass_out.ale        = al_misaligned;
    pass_out.inst_valid = ex_in.inst_valid;
    pass_out.pc         = ex_in.pc;
    pass_out.inst       = ex_in.inst;
    pass_out.wreg_index = ex_in.wreg_index;
    pass_out.wreg_en    = al_is_store ? 1'b0 : ex_in.wreg_en;
    pass_out.result     = ex_in.alu_result;

    mem_out             = '0;
    mem_out.ale         = 1'b0;
    mem_out.inst_valid  = iv_p0;
    mem_out.pc          = pc_p0;
    mem_out.inst        = inst_p0;
    mem_out.wreg_index  = widx_p0;
    mem_out.wreg_en     = wen_p0;
    mem_out.result      = we_p0 ? addr_p0 : al_load;
  end

  // ---- stage p0: capture accepted op and shape the memory request ----
  always_ff @(posedge clk) begin
    if (fire_in) begin
      op_p0    <= ex_in.mem_op;
      addr_p0  <= ex_in.alu_result;
      we_p0    <= al_is_store;
      wstrb_p0 <= al_wstrb;
      wdata_p0 <= al_wdata;
      iv_p0    <= ex_in.inst_valid;
      pc_p0    <= ex_in.pc;
      inst_p0  <= ex_in.inst;
      widx_p0  <= ex_in.wreg_index;
      wen_p0   <= al_is_store ? 1'b0 : ex_in.wreg_en;
    end
  end

  // ---- stage p1: control FSM and registered write-back output ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0 <= IDLE;
      req_p0   <= 1'b0;
      vld_p1   <= 1'b0;
      out_p1   <= '0;
    end else begin
      case (state_p0)
        IDLE, DONE: begin
          if (fire_in) begin
            if (!al_is_mem || al_misaligned) begin
              state_p0 <= DONE;
              vld_p1   <= 1'b1;
              out_p1   <= pass_out;
            end else begin
              state_p0 <= REQ;
              req_p0   <= 1'b1;
              vld_p1   <= 1'b0;
            end
          end else if (state_p0 == DONE && right_ready) begin
            state_p0 <= IDLE;
            vld_p1   <= 1'b0;
          end
        end
        REQ: begin
          if (data_addr_ok) begin
            req_p0 <= 1'b0;
            if (data_data_ok) begin
              state_p0 <= DONE;
              vld_p1   <= 1'b1;
              out_p1   <= mem_out;
            end else begin
              state_p0 <= WAIT;
            end
          end
        end
        WAIT: begin
          if (data_data_ok) begin
            state_p0 <= DONE;
            vld_p1   <= 1'b1;
            out_p1   <= mem_out;
          end
        end
        default: begin
          state_p0 <= IDLE;
          req_p0   <= 1'b0;
          vld_p1   <= 1'b0;
        end
      endcase
    end
  end

  assign right_valid  = vld_p1;
  assign mem_ctrl_bus = out_p1;
  assign data_req     = req_p0;
  assign data_we      = we_p0;
  assign data_wstrb   = wstrb_p0;
  assign data_addr    = addr_p0;
  assign data_wdata   = wdata_p0;

endmodule
